// File: rtl/sw_led_ctrl.sv
// sw_led_ctrl: debounced slide switch stepping an LED through
// OFF -> ON -> BLINK (-> DIM) -> OFF, one step per debounced press.
// Optional feature macro: LED_DIM_EN adds the DIM mode (25% duty).
// Without it mode 11 is unreachable. If it is ever entered by an upset,
// the LED stays dark and the next press returns to OFF.
module sw_led_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_HALF      = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw,
    output logic       led,
    output logic       sw_clean,
    output logic [1:0] mode
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int BL_W = $clog2(BLINK_HALF);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        M_OFF   = 2'b00,
        M_ON    = 2'b01,
        M_BLINK = 2'b10,
        M_DIM   = 2'b11
    } mode_t;

    mode_t           state;
    mode_t           state_nxt;
    logic            s1;
    logic            s2;
    logic [DB_W-1:0] db_cnt;
    logic            clean_q;
    logic            press;
    logic [BL_W-1:0] bl_cnt;
    logic            bl_phase;
    logic            led_nxt;
`ifdef LED_DIM_EN
    logic [1:0]      dim_cnt;
`endif

    assign mode = state;

    // Two-flop synchronizer. Nothing downstream looks at the raw switch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    // Debounce: count consecutive cycles where the synchronized level
    // disagrees with sw_clean. Any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt   <= '0;
            sw_clean <= 1'b0;
        end else if (s2 == sw_clean) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            sw_clean <= s2;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Registered copy of sw_clean, used to find the rising edge (press).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) clean_q <= 1'b0;
        else     clean_q <= sw_clean;
    end

    assign press = sw_clean & ~clean_q;

    // Mode state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= M_OFF;
        else     state <= state_nxt;
    end

    // Next mode on press, and the LED level that the current mode asks for.
    always_comb begin
        state_nxt = state;
        led_nxt   = 1'b0;
        case (state)
            M_OFF:   led_nxt = 1'b0;
            M_ON:    led_nxt = 1'b1;
            M_BLINK: led_nxt = bl_phase;
            M_DIM: begin
`ifdef LED_DIM_EN
                led_nxt = (dim_cnt == 2'd0);
`else
                led_nxt = 1'b0;
`endif
            end
            default: led_nxt = 1'b0;
        endcase
        if (press) begin
            case (state)
                M_OFF:   state_nxt = M_ON;
                M_ON:    state_nxt = M_BLINK;
`ifdef LED_DIM_EN
                M_BLINK: state_nxt = M_DIM;
`else
                M_BLINK: state_nxt = M_OFF;
`endif
                M_DIM:   state_nxt = M_OFF;
                default: state_nxt = M_OFF;
            endcase
        end
    end

    // LED drive register. It lags the mode by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) led <= 1'b0;
        else     led <= led_nxt;
    end

    // Blink timebase. Outside BLINK it is parked at count 0 with the phase lit,
    // so every entry into BLINK starts with a full lit half-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bl_cnt   <= '0;
            bl_phase <= 1'b1;
        end else if (state != M_BLINK) begin
            bl_cnt   <= '0;
            bl_phase <= 1'b1;
        end else if (bl_cnt == BL_LAST) begin
            bl_cnt   <= '0;
            bl_phase <= ~bl_phase;
        end else begin
            bl_cnt <= bl_cnt + BL_W'(1);
        end
    end

`ifdef LED_DIM_EN
    // DIM duty counter: free-running while in DIM and cleared otherwise.
    // The LED is lit on one count out of four.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                dim_cnt <= 2'd0;
        else if (state != M_DIM) dim_cnt <= 2'd0;
        else                    dim_cnt <= dim_cnt + 2'd1;
    end
`endif

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Bench for sw_led_ctrl with short timing parameters. A behavioural model
// works from sampled switch history: run lengths, modes and time spent in
// a mode. The bench checks all outputs every cycle and adds directed
// constant checks.
module tb_sw_led_ctrl;
    localparam int D = 4;
    localparam int B = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw  = 1'b0;
    logic       led;
    logic       sw_clean;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    // model state
    bit hist[$];
    bit seen[$];
    bit m_clean, m_clean_q, m_led;
    int m_mode, m_since;

    sw_led_ctrl #(.DEBOUNCE_CYCLES(D), .BLINK_HALF(B)) dut (
        .clk(clk), .rst(rst), .sw(sw), .led(led), .sw_clean(sw_clean), .mode(mode)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
        seen.delete();
        m_clean = 0; m_clean_q = 0; m_led = 0; m_mode = 0; m_since = 0;
    endfunction

    // One clock edge: the switch level seen by the debouncer is the value
    // sampled two edges ago. The clean level flips once the last D seen
    // values all differ from it.
    function automatic void model_edge(input bit x);
        bit s, flip, press, nled;
        int nmode;
        hist.push_back(x);
        s = hist[hist.size()-3];
        hist.pop_front();
        seen.push_back(s);
        if (seen.size() > D) seen.pop_front();
        flip = (seen.size() == D);
        foreach (seen[i]) if (seen[i] == m_clean) flip = 0;
        press = m_clean && !m_clean_q;
        case (m_mode)
            0: nled = 0;
            1: nled = 1;
            2: nled = ((m_since / B) % 2) == 0;
`ifdef LED_DIM_EN
            default: nled = (m_since % 4) == 0;
`else
            default: nled = 0;
`endif
        endcase
        nmode = m_mode;
        if (press) begin
            if (m_mode == 0)      nmode = 1;
            else if (m_mode == 1) nmode = 2;
`ifdef LED_DIM_EN
            else if (m_mode == 2) nmode = 3;
`endif
            else                  nmode = 0;
        end
        m_since   = (nmode != m_mode) ? 0 : m_since + 1;
        m_mode    = nmode;
        m_led     = nled;
        m_clean_q = m_clean;
        if (flip) m_clean = ~m_clean;
    endfunction

    task automatic tick(input bit swv);
        sw = swv;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(swv);
        #1;
        chk("led", 8'(led), 8'(m_led));
        chk("sw_clean", 8'(sw_clean), 8'(m_clean));
        chk("mode", 8'(mode), 8'(m_mode));
    endtask

    initial begin
        bit cur;
        int len;
        model_reset();
        // reset held for 3 cycles with sw=0
        rst = 1'b1;
        repeat (3) tick(1'b0);
        rst = 1'b0;
        tick(1'b0);
        chk("rst_led", 8'(led), 8'd0);
        chk("rst_mode", 8'(mode), 8'd0);
        chk("rst_clean", 8'(sw_clean), 8'd0);

        // short glitches never reach sw_clean
        repeat (5) begin
            repeat (3) tick(1'b1);
            repeat (3) tick(1'b0);
            chk("glitch_clean", 8'(sw_clean), 8'd0);
            chk("glitch_mode", 8'(mode), 8'd0);
        end
        repeat (6) tick(1'b0);

        // first press: latency D+2 edges, then mode, then led
        repeat (5) tick(1'b1);
        chk("lat_clean_early", 8'(sw_clean), 8'd0);
        tick(1'b1);
        chk("lat_clean", 8'(sw_clean), 8'd1);
        chk("lat_mode_early", 8'(mode), 8'd0);
        tick(1'b1);
        chk("press_mode", 8'(mode), 8'd1);
        chk("press_led_early", 8'(led), 8'd0);
        tick(1'b1);
        chk("press_led", 8'(led), 8'd1);

        // release is not a press
        repeat (10) tick(1'b0);
        chk("release_mode", 8'(mode), 8'd1);

        // second press: BLINK, then check 1x8 0x8 1x8
        repeat (7) tick(1'b1);
        chk("blink_mode", 8'(mode), 8'd2);
        for (int k = 0; k < 24; k++) begin
            tick(1'b1);
            chk("blink_seq", 8'(led), ((k / 8) % 2 == 0) ? 8'd1 : 8'd0);
        end

        // third press
        repeat (10) tick(1'b0);
        repeat (7) tick(1'b1);
`ifdef LED_DIM_EN
        chk("third_mode", 8'(mode), 8'd3);
        for (int k = 0; k < 8; k++) begin
            tick(1'b1);
            chk("dim_seq", 8'(led), (k % 4 == 0) ? 8'd1 : 8'd0);
        end
`else
        chk("third_mode", 8'(mode), 8'd0);
        tick(1'b1);
        chk("third_led", 8'(led), 8'd0);
`endif

        // randomized bouncing runs against the model
        cur = 1'b0;
        for (int r = 0; r < 120; r++) begin
            cur = ~cur;
            len = $urandom_range(1, 3 * B);
            repeat (len) tick(cur);
        end

        // reach BLINK with led dark, then reset asynchronously
        for (int it = 0; it < 40 && m_mode != 2; it++) begin
            repeat (8) tick(1'b0);
            for (int j = 0; j < 8 && m_mode != 2; j++) tick(1'b1);
        end
        chk("reach_blink", 8'(mode), 8'd2);
        for (int j = 0; j < 20 && m_led != 0; j++) tick(1'b1);
        chk("blink_dark", 8'(led), 8'd0);
        repeat (3) tick(1'b1);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_led", 8'(led), 8'd0);
        chk("async_mode", 8'(mode), 8'd0);
        chk("async_clean", 8'(sw_clean), 8'd0);
        repeat (2) tick(1'b1);
        rst = 1'b0;
        // sw held 1 through release counts as a press after 7 edges
        repeat (6) tick(1'b1);
        chk("rel_mode_early", 8'(mode), 8'd0);
        tick(1'b1);
        chk("rel_mode", 8'(mode), 8'd1);
        tick(1'b1);
        chk("rel_led", 8'(led), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
